c432_key_loader: RTL and testbench
==================================

# c432_key_loader

Serial key-load front end that sits directly upstream of the key-locked c432 core. It receives a 43-bit key frame plus CRC-8 over a one-bit valid/ready stream and checks the CRC. On a pass it drives the core's 32 MUX-select key inputs (p1..p32) and 11 XOR key inputs (X_1..X_11) from registered outputs. Failed loads are counted, and repeated failure locks the loader out until reset.

## Interface
- MAX_FAIL, 3: failed CRC checks before permanent lockout (range 1..7).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- bit_in  in  1  serial frame data.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  loader accepts a bit this cycle; high only in LOAD.
- key_p  out  32  key_p[i] drives p(i+1) of the core.
- key_x  out  11  key_x[j] drives X_(j+1) of the core.
- armed  out  1  key outputs hold a CRC-verified key.
- err  out  1  one-cycle pulse on a CRC failure.
- lockout  out  1  sticky; fail count reached MAX_FAIL.
- busy  out  1  high in LOAD or CHECK.

## Operation
- States: IDLE, LOAD, CHECK, ARMED, ERROR, LOCKOUT.
- IDLE: on load_start, go to LOAD. Clear bit counter, CRC accumulator and shift registers.
- LOAD: bit_ready=1. Each cycle with bit_valid=1 accepts one bit and increments the 6-bit counter.
  - Frame order: bits 0..31 map to key_p[0..31], then bits 32..42 map to key_x[0..10].
  - Frame bits 43..50 carry the CRC byte, MSB first.
  - When the accept that brings the count to 51 occurs, go to CHECK.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, computed serially over the 43 key bits only.
  - Per key bit: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0x00).
- CHECK: one cycle; compare the accumulated CRC with the received byte.
  - Match: go to ARMED. key_p/key_x load from the shift register on that same edge, and armed=1.
  - Mismatch: go to ERROR and increment fail_cnt (3 bits, saturating).
- ERROR: one cycle, err=1.
  - If fail_cnt == MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
- ARMED: terminal until rst. load_start and bit_valid are ignored, and key outputs are frozen.
- LOCKOUT: terminal until rst. lockout=1, and key_p=0, key_x=0, armed=0.
- Key outputs are all-zero in every state except ARMED. The core never sees a partial or unverified key.
- load_start while not in IDLE is ignored. A load_start in the same cycle as the ERROR→IDLE transition is ignored; the request must be held into IDLE.
- fail_cnt is not cleared by a successful load; it clears only on rst.

## Timing
- Reset values: state=IDLE, key_p=0, key_x=0, armed=0, err=0, lockout=0, busy=0, bit_ready=0, fail_cnt=0.
- rst takes priority over every event, including mid-LOAD and same-cycle load_start. The next cycle is IDLE with all outputs at their reset values.
- load_start at edge N puts the loader in LOAD at N+1; bit_ready is high from cycle N+1.
- Minimum frame with bit_valid held high is 51 cycles in LOAD, then 1 in CHECK. armed rises at edge N+53 relative to load_start at edge N.
- Failure path: err is high for exactly one cycle, immediately after CHECK. lockout rises on the edge leaving ERROR.
- Gaps in bit_valid stall the load indefinitely. There is no timeout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package c432_key_pkg holds:
  - Constants: KEY_P_W=32, KEY_X_W=11, KEY_W=43, CRC_W=8, FRAME_W=51, CRC_POLY=8'h07.
  - The state enum typedef.
- Sub-module crc8_serial: clk, rst, clr, en, bit_in, crc[7:0]. It is also reusable by other key-locked benchmark wrappers.
- Top module contains the FSM, bit counter, 43-bit key shift register, 8-bit received-CRC register, fail counter and output registers.

## Test plan
- All-zero key plus CRC 0x00, bit_valid held high → armed=1 at cycle 53 after load_start; key_p=0, key_x=0.
- Key with only bit 42 set plus CRC 0x07 → armed=1; key_x=11'h400, key_p=0.
- All-zero key plus CRC 0x01 → err pulses once; state returns to IDLE; fail_cnt=1; keys stay 0. Three such frames with MAX_FAIL=3 → lockout=1, and a fourth load_start is ignored (bit_ready stays 0).
- Valid frame with bit_valid toggling 1/0 → armed at cycle 104; an extra load_start and bit traffic after arming leave key_p/key_x unchanged.
- rst asserted after 20 accepted bits → all outputs at reset values next cycle. A following full valid frame arms correctly, and fail_cnt is 0.
- load_start during LOAD or CHECK → no effect; the frame completes and the verdict is unchanged.

Source files
------------

// File: rtl/c432_key_pkg.sv
// Shared constants and state encoding for the c432 serial key loader.
package c432_key_pkg;

    localparam int unsigned KEY_P_W = 32;
    localparam int unsigned KEY_X_W = 11;
    localparam int unsigned KEY_W   = 43;
    localparam int unsigned CRC_W   = 8;
    localparam int unsigned FRAME_W = 51;
    localparam logic [7:0]  CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StArmed,
        StError,
        StLockout
    } state_e;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator, MSB-first, zero initial value.
module crc8_serial
    import c432_key_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[CRC_W-1] ^ bit_in;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/c432_key_loader.sv
// Serial key-frame loader for the key-locked c432 core: CRC-checked, with
// failure counting and permanent lockout.
module c432_key_loader
    import c432_key_pkg::*;
#(
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [KEY_P_W-1:0] key_p,
    output logic [KEY_X_W-1:0] key_x,
    output logic               armed,
    output logic               err,
    output logic               lockout,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_sr_q, key_sr_d;
    logic [CRC_W-1:0]   crc_rx_q, crc_rx_d;
    logic [2:0]         fail_q, fail_d;
    logic [KEY_P_W-1:0] key_p_q, key_p_d;
    logic [KEY_X_W-1:0] key_x_q, key_x_d;
    logic               crc_clr, crc_en;
    logic [CRC_W-1:0]   crc_acc;
    logic               in_key;

    assign in_key = (cnt_q < 6'(KEY_W));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_sr_d = key_sr_q;
        crc_rx_d = crc_rx_q;
        fail_d   = fail_q;
        key_p_d  = key_p_q;
        key_x_d  = key_x_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    key_sr_d = '0;
                    crc_rx_d = '0;
                    crc_clr  = 1'b1;
                end
            end
            StLoad: begin
                if (bit_valid) begin
                    cnt_d  = cnt_q + 6'd1;
                    crc_en = in_key;
                    // Right shift lands frame bit 0 in key_sr_q[0] after 43 key bits.
                    if (in_key) begin
                        key_sr_d = {bit_in, key_sr_q[KEY_W-1:1]};
                    end else begin
                        crc_rx_d = {crc_rx_q[CRC_W-2:0], bit_in};
                    end
                    if (cnt_q == 6'(FRAME_W - 1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (crc_acc == crc_rx_q) begin
                    state_d = StArmed;
                    key_p_d = key_sr_q[KEY_P_W-1:0];
                    key_x_d = key_sr_q[KEY_W-1:KEY_P_W];
                end else begin
                    state_d = StError;
                    if (fail_q != 3'd7) begin
                        fail_d = fail_q + 3'd1;
                    end
                end
            end
            StError: begin
                state_d = (fail_q == 3'(MAX_FAIL)) ? StLockout : StIdle;
            end
            StArmed:   state_d = StArmed;
            StLockout: state_d = StLockout;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            key_sr_q <= '0;
            crc_rx_q <= '0;
            fail_q   <= '0;
            key_p_q  <= '0;
            key_x_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_sr_q <= key_sr_d;
            crc_rx_q <= crc_rx_d;
            fail_q   <= fail_d;
            key_p_q  <= key_p_d;
            key_x_q  <= key_x_d;
        end
    end

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bit_in),
        .crc    (crc_acc)
    );

    // Status outputs decode only the state register, so no input reaches an output combinationally.
    assign key_p     = key_p_q;
    assign key_x     = key_x_q;
    assign bit_ready = (state_q == StLoad);
    assign busy      = (state_q == StLoad) || (state_q == StCheck);
    assign armed     = (state_q == StArmed);
    assign err       = (state_q == StError);
    assign lockout   = (state_q == StLockout);

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader with a verdict scoreboard and a reference CRC-8 model.
module tb_c432_key_loader;

    localparam int unsigned MaxFail = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [31:0] key_p;
    logic [10:0] key_x;
    logic        armed, err, lockout, busy;

    int checks = 0;
    int failures = 0;
    int model_fails = 0;

    typedef struct {
        bit          pass;
        logic [31:0] kp;
        logic [10:0] kx;
        int          lat;
        bit          lock;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    c432_key_loader #(.MAX_FAIL(MaxFail)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .key_p      (key_p),
        .key_x      (key_x),
        .armed      (armed),
        .err        (err),
        .lockout    (lockout),
        .busy       (busy)
    );

    function automatic logic [7:0] crc_ref(input logic [42:0] k);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < 43; i++) begin
            c = (c << 1) ^ ((c[7] ^ k[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, 64'({bit_ready, key_p, key_x, armed, err, lockout, busy}), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_start = 1'b0;
        bit_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_fails = 0;
    endtask

    task automatic send_frame(input logic [42:0] key, input logic [7:0] crc, input bit toggle,
                              input bit ls_noise, output int edges);
        exp_t e;
        e.pass = (crc == crc_ref(key));
        e.kp   = e.pass ? key[31:0] : 32'd0;
        e.kx   = e.pass ? key[42:32] : 11'd0;
        e.lat  = toggle ? 104 : 53;
        if (!e.pass) model_fails++;
        e.lock = !e.pass && (model_fails >= int'(MaxFail));
        sb.push_back(e);
        edges = 0;
        load_start = 1'b1;
        step();
        edges++;
        load_start = ls_noise;
        chk("bit_ready_in_load", 64'(bit_ready), 64'd1);
        for (int k = 0; k < 51; k++) begin
            if (toggle) begin
                bit_valid = 1'b0;
                bit_in = 1'($urandom());
                step();
                edges++;
            end
            bit_valid = 1'b1;
            bit_in = (k < 43) ? key[k] : crc[7-(k-43)];
            step();
            edges++;
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic wait_verdict(input int edges_in, input bit ls_in_error);
        exp_t e;
        int   edges = edges_in;
        bit   seen = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            edges++;
            load_start = 1'b0;
            if (armed || err) seen = 1'b1;
        end
        load_start = 1'b0;
        chk("verdict_seen", 64'(seen), 64'd1);
        chk("verdict_latency", 64'(edges), 64'(e.lat));
        chk("verdict_armed", 64'(armed), 64'(e.pass));
        chk("verdict_err", 64'(err), 64'(!e.pass));
        chk("verdict_key_p", 64'(key_p), 64'(e.kp));
        chk("verdict_key_x", 64'(key_x), 64'(e.kx));
        if (!e.pass) begin
            load_start = ls_in_error;
            step();
            load_start = 1'b0;
            chk("err_one_cycle", 64'(err), 64'd0);
            chk("lockout_after_err", 64'(lockout), 64'(e.lock));
            chk("bit_ready_after_err", 64'(bit_ready), 64'd0);
            step();
            chk("no_restart_after_err", 64'(bit_ready), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ed;
        logic [42:0] k;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle_outputs("reset_values");

        // All-zero key, CRC 0x00.
        send_frame(43'd0, 8'h00, 1'b0, 1'b0, ed);
        wait_verdict(ed, 1'b0);
        do_reset();

        // Only key bit 42 set, CRC 0x07.
        k = 43'd0;
        k[42] = 1'b1;
        send_frame(k, 8'h07, 1'b0, 1'b0, ed);
        wait_verdict(ed, 1'b0);
        do_reset();

        k = 43'({$urandom(), $urandom()});
        send_frame(k, crc_ref(k), 1'b0, 1'b0, ed);
        wait_verdict(ed, 1'b0);
        do_reset();

        // Three bad frames lock the loader out; the first holds load_start through ERROR.
        for (int i = 0; i < 3; i++) begin
            send_frame(43'd0, 8'h01, 1'b0, 1'b0, ed);
            wait_verdict(ed, (i == 0));
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        step();
        chk("lockout_ignores_start", 64'({bit_ready, busy, armed, key_p, key_x}), 64'd0);
        chk("lockout_sticky", 64'(lockout), 64'd1);
        do_reset();

        // Toggling bit_valid, then post-arm traffic must not disturb the key.
        k = 43'({$urandom(), $urandom()});
        send_frame(k, crc_ref(k), 1'b1, 1'b0, ed);
        wait_verdict(ed, 1'b0);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom());
            step();
        end
        bit_valid = 1'b0;
        chk("armed_key_frozen", 64'({key_x, key_p}), 64'(k));
        chk("armed_hold", 64'({armed, bit_ready, busy}), 64'b100);
        do_reset();

        // Two failures, mid-load reset with same-cycle load_start, then fail count must restart.
        for (int i = 0; i < 2; i++) begin
            send_frame(43'd0, 8'h01, 1'b0, 1'b0, ed);
            wait_verdict(ed, 1'b0);
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom());
            step();
        end
        rst = 1'b1;
        load_start = 1'b1;
        bit_valid = 1'b0;
        step();
        rst = 1'b0;
        load_start = 1'b0;
        model_fails = 0;
        chk_idle_outputs("reset_mid_load");
        for (int i = 0; i < 2; i++) begin
            send_frame(43'd0, 8'h01, 1'b0, 1'b0, ed);
            wait_verdict(ed, 1'b0);
        end
        k = 43'({$urandom(), $urandom()});
        send_frame(k, crc_ref(k), 1'b0, 1'b0, ed);
        wait_verdict(ed, 1'b0);
        do_reset();

        // load_start held through LOAD and CHECK has no effect on the verdict.
        k = 43'({$urandom(), $urandom()});
        send_frame(k, crc_ref(k), 1'b0, 1'b1, ed);
        wait_verdict(ed, 1'b0);
        do_reset();
        send_frame(k, crc_ref(k) ^ 8'h80, 1'b0, 1'b1, ed);
        wait_verdict(ed, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
